fwd_hazard_scoreboard: RTL



---
 rtl/cpu_pkg.sv | 17 +
 rtl/fwd_select.sv | 26 ++
 rtl/fwd_hazard_scoreboard.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the forwarding/hazard scoreboard: stage record, FSM states.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int FWD_NONE   = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  multicycle;
  } stage_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mc_state_t;
endpackage

// File: rtl/fwd_select.sv
// Priority matcher for one EX operand: youngest downstream producer wins.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int SEL_W          = 2
) (
  input  logic [REG_ADDR_W-1:0]         i_addr,
  input  stage_t [NUM_FWD_STAGES:0]     i_stage,
  output logic [SEL_W-1:0]              o_sel
);
  // The record carries fields this matcher never looks at.
  logic w_unused;
  assign w_unused = ^i_stage;

  // Scan oldest to youngest so the smallest matching distance overrides.
  always_comb begin
    o_sel = SEL_W'(FWD_NONE);
    for (int d = NUM_FWD_STAGES; d >= 1; d--) begin
      if (i_stage[d].valid && i_stage[d].regwrite &&
          (i_stage[d].rd != '0) && (i_stage[d].rd == i_addr))
        o_sel = SEL_W'(NUM_FWD_STAGES + 1 - d);
    end
    if (!i_stage[0].valid) o_sel = SEL_W'(FWD_NONE);
  end
endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and hazard unit with its own in-flight record of EX and the
// downstream stages; handles load-use stalls and multi-cycle EX occupancy.
module fwd_hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter  int NUM_FWD_STAGES = 2,
  parameter  int LOAD_READY     = 2,
  parameter  int MC_LATENCY     = 4,
  localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  id_multicycle_i,
  input  logic                  flush_i,
  output logic [SEL_W-1:0]      fwd_rs_o,
  output logic [SEL_W-1:0]      fwd_rt_o,
  output logic                  stall_o,
  output logic                  ex_hold_o,
  output logic                  mc_busy_o
);
  localparam int CNT_W = $clog2(MC_LATENCY + 1);

  stage_t [NUM_FWD_STAGES:0]      r_stage;
  mc_state_t                      r_state, w_state_nxt;
  logic [CNT_W-1:0]               r_cnt, w_cnt_nxt;
  stage_t                         w_id_entry;
  logic                           w_busy, w_load_use, w_stall;
  logic [1:0][REG_ADDR_W-1:0]     w_opnd;
  logic [1:0][SEL_W-1:0]          w_sel;

  assign w_busy = (r_state == BUSY);

  // Entry EX will capture on a normal advance; a flushed instruction enters dead.
  always_comb begin
    w_id_entry            = '0;
    w_id_entry.valid      = id_valid_i & ~flush_i;
    w_id_entry.rs         = id_rs_i;
    w_id_entry.rt         = id_rt_i;
    w_id_entry.rd         = id_rd_i;
    w_id_entry.regwrite   = id_regwrite_i;
    w_id_entry.memread    = id_memread_i;
    w_id_entry.multicycle = id_multicycle_i;
  end

  // Load-use: a load still too young to forward targets an ID source.
  always_comb begin
    w_load_use = 1'b0;
    for (int d = 1; d < LOAD_READY; d++) begin
      if (r_stage[d-1].valid && r_stage[d-1].memread && r_stage[d-1].regwrite &&
          (r_stage[d-1].rd != '0) &&
          ((r_stage[d-1].rd == id_rs_i) || (r_stage[d-1].rd == id_rt_i)))
        w_load_use = 1'b1;
    end
  end

  // A killed ID instruction cannot create a hazard; BUSY always stalls.
  assign w_stall   = w_busy | (id_valid_i & ~flush_i & w_load_use);
  assign stall_o   = w_stall;
  assign ex_hold_o = w_busy;
  assign mc_busy_o = w_busy;

  // Next state: BUSY is entered on the edge a live multi-cycle op is loaded
  // into EX, so the same entry never re-arms while it sits held in EX.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == IDLE) begin
      if (!w_stall && w_id_entry.valid && id_multicycle_i) begin
        w_state_nxt = BUSY;
        w_cnt_nxt   = CNT_W'(MC_LATENCY - 1);
      end
    end else begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) w_state_nxt = IDLE;
    end
  end

  // FSM state and occupancy counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pipeline record advance: hold EX when busy, bubble EX on load-use.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stage <= '0;
    end else begin
      for (int d = NUM_FWD_STAGES; d >= 2; d--) r_stage[d] <= r_stage[d-1];
      if (w_busy) begin
        r_stage[1] <= '0;
      end else begin
        r_stage[1] <= r_stage[0];
        r_stage[0] <= w_stall ? '0 : w_id_entry;
      end
    end
  end

  assign w_opnd[0] = r_stage[0].rs;
  assign w_opnd[1] = r_stage[0].rt;

  for (genvar g = 0; g < 2; g++) begin : g_opnd
    fwd_select #(
      .NUM_FWD_STAGES (NUM_FWD_STAGES),
      .SEL_W          (SEL_W)
    ) u_sel (
      .i_addr  (w_opnd[g]),
      .i_stage (r_stage),
      .o_sel   (w_sel[g])
    );
  end

  assign fwd_rs_o = w_sel[0];
  assign fwd_rt_o = w_sel[1];
endmodule
